tb_wr_ctrl: RTL and testbench

- Write-port sequencer for the temp buffer (TB) port B.
- Accepts a burst command (direction, l_k_0, base address, beat count).
- Paces column beats from the systolic array C output, and drives TB_dinb_sel/l_k_0 into the TB_dinb mapping stage.
- Generates TB port-B enable, per-lane write enables and address, aligned with that stage's one-cycle registered output.

---
 rtl/tb_wr_ctrl_pkg.sv | 36 +++
 rtl/tb_wr_ctrl_addr_gen.sv | 21 ++
 rtl/tb_wr_ctrl.sv | 106 ++++++++++
 tb/tb_tb_wr_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tb_wr_ctrl_pkg.sv
// Shared codes for the TB port-B write sequencer: burst directions, NEW-mode
// half selects, FSM state encoding and the per-lane write-enable mask.
package tb_wr_ctrl_pkg;

  localparam int TB_L = 4;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_IDLE = 2'b00;
  localparam dir_t DIR_POS  = 2'b01;
  localparam dir_t DIR_NEG  = 2'b10;
  localparam dir_t DIR_NEW  = 2'b11;

  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  // NEW mode writes one half of the lanes: l_k_0=1 selects the low half.
  function automatic logic [TB_L-1:0] lane_mask(input dir_t dir, input logic l_k_0);
    logic [TB_L-1:0] m;
    m = '0;
    case (dir)
      DIR_POS, DIR_NEG: m = '1;
      DIR_NEW: begin
        if (l_k_0 == DIR_NEW_1) m = {{(TB_L/2){1'b0}}, {(TB_L/2){1'b1}}};
        else                    m = {{(TB_L/2){1'b1}}, {(TB_L/2){1'b0}}};
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tb_wr_ctrl_addr_gen.sv
// Up/down TB address counter: load the burst base, then step once per beat.
module tb_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          step,
  input  logic          down,
  output logic [AW-1:0] addr
);

  // Wrap past 0 or 2^AW-1 is silent modulo arithmetic.
  always_ff @(posedge clk) begin
    if (sys_rst)   addr <= '0;
    else if (load) addr <= base;
    else if (step) addr <= down ? addr - AW'(1) : addr + AW'(1);
  end

endmodule

// File: rtl/tb_wr_ctrl.sv
// TB port-B write sequencer: paces C column beats into the TB_dinb mapping
// stage and issues enable/mask/address one cycle later to match its register.
//
// state   | meaning
// IDLE    | waiting for a burst command (cmd_ready=1)
// RUN     | accepting column beats (c_ready=1)
// LAST    | final write on TB port B, done pulse
module tb_wr_ctrl
  import tb_wr_ctrl_pkg::*;
#(
  parameter int L     = TB_L,
  parameter int TB_AW = 10,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_dir,
  input  logic             cmd_l_k_0,
  input  logic [TB_AW-1:0] cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             c_valid,
  output logic             c_ready,
  output logic [1:0]       TB_dinb_sel,
  output logic             l_k_0,
  output logic             TB_enb,
  output logic [L-1:0]     TB_web,
  output logic [TB_AW-1:0] TB_addrb,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q;
  dir_t             dir_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [TB_AW-1:0] addr_cur;
  logic             cmd_acc;
  logic             beat_acc;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = ~cmd_ready;
  assign c_ready     = (state_q == ST_RUN);
  assign done        = (state_q == ST_LAST);
  assign cmd_acc     = cmd_ready & cmd_valid;
  assign beat_acc    = c_ready & c_valid;
  assign TB_dinb_sel = beat_acc ? dir_q : DIR_IDLE;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      l_k_0   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            dir_q   <= cmd_dir;
            l_k_0   <= cmd_l_k_0;
            len_q   <= cmd_len;
            cnt_q   <= '0;
            state_q <= (cmd_len == '0) ? ST_LAST : ST_RUN;
          end
        end
        ST_RUN: begin
          if (c_valid) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_q <= ST_LAST;
          end
        end
        ST_LAST: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tb_addr_gen #(.AW(TB_AW)) u_addr_gen (
    .clk     (clk),
    .sys_rst (sys_rst),
    .load    (cmd_acc),
    .base    (cmd_base),
    .step    (beat_acc),
    .down    (dir_q == DIR_NEG),
    .addr    (addr_cur)
  );

  // Flush bursts consume beats without writing, so the address is left alone.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      TB_enb   <= 1'b0;
      TB_web   <= '0;
      TB_addrb <= '0;
    end else if (beat_acc && dir_q != DIR_IDLE) begin
      TB_enb   <= 1'b1;
      TB_web   <= lane_mask(dir_q, l_k_0);
      TB_addrb <= addr_cur;
    end else begin
      TB_enb   <= 1'b0;
      TB_web   <= '0;
    end
  end

endmodule

// File: tb/tb_tb_wr_ctrl.sv
// Randomized bench for tb_wr_ctrl: driver predicts writes/done into queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_tb_wr_ctrl;
  import tb_wr_ctrl_pkg::*;

  localparam int L  = 4;
  localparam int AW = 10;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dir;
  logic          cmd_l_k_0;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic          c_valid;
  logic          c_ready;
  logic [1:0]    TB_dinb_sel;
  logic          l_k_0;
  logic          TB_enb;
  logic [L-1:0]  TB_web;
  logic [AW-1:0] TB_addrb;
  logic          busy;
  logic          done;

  tb_wr_ctrl #(.L(L), .TB_AW(AW), .LEN_W(LW)) dut (
    .clk(clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_l_k_0(cmd_l_k_0), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .c_valid(c_valid), .c_ready(c_ready), .TB_dinb_sel(TB_dinb_sel), .l_k_0(l_k_0),
    .TB_enb(TB_enb), .TB_web(TB_web), .TB_addrb(TB_addrb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [L-1:0]  web;
  } wr_t;

  wr_t           wr_q[$];
  int            done_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          rst_edge = 1'b0;
  logic [AW-1:0] hold_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference lane mask, straight from the direction table.
  function automatic logic [L-1:0] model_mask(input logic [1:0] dir, input logic lk);
    if (dir == 2'b01 || dir == 2'b10) return 4'b1111;
    if (dir == 2'b11) return lk ? 4'b0011 : 4'b1100;
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = sys_rst;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      chk("rst_enb", TB_enb, 0);
      chk("rst_web", TB_web, 0);
      chk("rst_addrb", TB_addrb, 0);
      chk("rst_l_k_0", l_k_0, 0);
      chk("rst_done", done, 0);
      chk("rst_c_ready", c_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      hold_addr = '0;
    end else begin
      if (TB_enb) begin
        if (wr_q.size() == 0) chk("unexpected_write", TB_enb, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_addr", TB_addrb, w.addr);
          chk("wr_web", TB_web, w.web);
          hold_addr = w.addr;
        end
      end else begin
        if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
          chk("wr_missing", TB_enb, 1);
          void'(wr_q.pop_front());
        end
        chk("nowr_web", TB_web, 0);
        chk("nowr_addr_hold", TB_addrb, hold_addr);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", done, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() != 0 && done_q[0] == cyc) begin
        chk("done_missing", done, 1);
        void'(done_q.pop_front());
      end
    end
  end

  // mode 0: continuous c_valid, 1: pattern bits, 2: random gaps.
  // rst_at >= 0 raises sys_rst on the cycle that would carry beat rst_at.
  task automatic burst(input logic [1:0] dir, input logic lk, input logic [AW-1:0] base,
                       input int len, input int mode, input logic [15:0] pat, input int rst_at);
    int            k;
    int            t;
    int            waitc;
    logic          cv;
    logic [AW-1:0] a;
    wr_t           w;
    k = 0;
    t = 0;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_l_k_0 = lk;
    cmd_base  = base;
    cmd_len   = LW'(len);
    if (len == 0) done_q.push_back(cyc + 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dir   = 2'($urandom);
    cmd_l_k_0 = 1'($urandom);
    cmd_base  = AW'($urandom);
    cmd_len   = LW'($urandom);
    while (k < len) begin
      if (mode == 0)      cv = 1'b1;
      else if (mode == 1) cv = pat[t];
      else                cv = ($urandom_range(0, 2) != 0);
      if (rst_at >= 0 && k == rst_at) begin
        cv = 1'b1;
        sys_rst = 1'b1;
      end
      c_valid = cv;
      #1;
      chk("c_ready_run", c_ready, 1);
      chk("cmd_ready_run", cmd_ready, 0);
      chk("dinb_sel", TB_dinb_sel, cv ? dir : 2'b00);
      if (sys_rst) begin
        @(negedge clk);
        sys_rst = 1'b0;
        c_valid = 1'b0;
        return;
      end
      if (cv) begin
        a = (dir == 2'b10) ? base - AW'(k) : base + AW'(k);
        if (dir != 2'b00) begin
          w.cyc  = cyc + 1;
          w.addr = a;
          w.web  = model_mask(dir, lk);
          wr_q.push_back(w);
        end
        if (k == len - 1) done_q.push_back(cyc + 1);
        k++;
      end
      t++;
      @(negedge clk);
    end
    // LAST: a stray beat must not be taken.
    c_valid = 1'b1;
    #1;
    chk("c_ready_last", c_ready, 0);
    chk("dinb_sel_last", TB_dinb_sel, 0);
    chk("busy_last", busy, 1);
    chk("l_k_0", l_k_0, lk);
    @(negedge clk);
    c_valid = 1'b0;
    #1;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 2'b00;
    cmd_l_k_0 = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    c_valid   = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);

    burst(DIR_POS, 1'b0, 10'd5, 3, 0, 16'h0, -1);
    burst(DIR_NEG, 1'b0, 10'd2, 4, 0, 16'h0, -1);
    burst(DIR_NEW, 1'b0, 10'd8, 2, 1, 16'b1001, -1);
    burst(DIR_POS, 1'b0, 10'd40, 0, 0, 16'h0, -1);
    burst(DIR_POS, 1'b0, 10'd20, 4, 0, 16'h0, 2);
    burst(DIR_NEW, 1'b1, 10'd1021, 5, 2, 16'h0, -1);
    burst(DIR_IDLE, 1'b1, 10'd30, 3, 0, 16'h0, -1);
    for (int i = 0; i < 30; i++) begin
      burst(2'($urandom_range(0, 3)), 1'($urandom), AW'($urandom),
            $urandom_range(0, 6), 2, 16'h0, -1);
    end

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
